// File: rtl/issue_queue_pkg.sv
// Shared types and widths for the decode-to-issue queue.
// Element layout is what decode hands over per instruction slot.
`ifndef ISSUE_QUEUE_PKG_SV
`define ISSUE_QUEUE_PKG_SV
`define TRUE 1'b1
`define FALSE 1'b0

package issue_queue_pkg;

    localparam int DECODE_WIDTH = 4;
    localparam int ISSUE_WIDTH = 2;

    typedef logic bool;

    typedef enum logic [1:0] {
        REQ_ALU,
        REQ_MUL,
        REQ_LSU,
        REQ_BRU
    } DECODE_REQUIRE;

    typedef struct packed {
        logic [31:0]   pc;
        logic [6:0]    opcode;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [31:0]   imm;
        DECODE_REQUIRE require;
    } ISSUE_QUEUE_ELEMENT;

endpackage

`endif

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/count bookkeeping for the issue queue, including the
// push/pop clamps, sticky protocol-violation flag and slot indices.
module iq_ptr_ctrl
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ISSUE_W = ISSUE_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [2:0]       push_number,
    input  logic [1:0]       pop_number,
    output logic [PTR_W-1:0] wr_idx [DECODE_WIDTH],
    output logic [DECODE_WIDTH-1:0] wr_en,
    output logic [PTR_W-1:0] rd_idx [ISSUE_W],
    output logic [CNT_W-1:0] count,
    output bool              overflow_err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DECODE_C = CNT_W'(DECODE_WIDTH);
    localparam logic [CNT_W-1:0] ISSUE_C = CNT_W'(ISSUE_W);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] push_req;
    logic [CNT_W-1:0] pop_req;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] n_pop;
    logic             push_err;
    logic             pop_err;

    // Free space is taken from the pre-pop count, so a push never
    // depends on what issue accepts in the same cycle.
    always_comb begin
        free = DEPTH_C - count;
        push_req = CNT_W'(push_number);
        pop_req = CNT_W'(pop_number);
        n_push = push_req;
        if (n_push > DECODE_C) n_push = DECODE_C;
        if (n_push > free) n_push = free;
        n_pop = pop_req;
        if (n_pop > ISSUE_C) n_pop = ISSUE_C;
        if (n_pop > count) n_pop = count;
        push_err = (push_req > DECODE_C) || (push_req > free);
        pop_err = pop_req > count;
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            wr_idx[i] = tail + PTR_W'(i);
            wr_en[i] = !flush && (CNT_W'(i) < n_push);
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_idx[k] = head + PTR_W'(k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            overflow_err <= `FALSE;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + n_pop[PTR_W-1:0];
            tail <= tail + n_push[PTR_W-1:0];
            count <= count + n_push - n_pop;
            if (push_err || pop_err) overflow_err <= `TRUE;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order circular queue between decode (up to 4 pushes) and
// issue (up to ISSUE_W pops), oldest entries presented at the head.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ISSUE_W = ISSUE_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  ISSUE_QUEUE_ELEMENT [DECODE_WIDTH-1:0] push_elements,
    input  logic [2:0]                          issue_queue_push_number,
    output logic [2:0]                          iq_size_left,
    output ISSUE_QUEUE_ELEMENT [ISSUE_W-1:0]    issue_elements,
    output bool [ISSUE_W-1:0]                   issue_valid,
    input  logic [1:0]                          issue_pop_number,
    output bool                                 overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(DECODE_WIDTH);

    logic [PTR_W-1:0]   wr_idx [DECODE_WIDTH];
    logic [DECODE_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0]   rd_idx [ISSUE_W];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   free;
    ISSUE_QUEUE_ELEMENT mem [DEPTH];

    iq_ptr_ctrl #(
        .DEPTH(DEPTH),
        .ISSUE_W(ISSUE_W)
    ) u_ptr (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push_number(issue_queue_push_number),
        .pop_number(issue_pop_number),
        .wr_idx(wr_idx),
        .wr_en(wr_en),
        .rd_idx(rd_idx),
        .count(count),
        .overflow_err(overflow_err)
    );

    // Storage holds no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= push_elements[i];
        end
    end

    always_comb begin
        free = DEPTH_C - count;
        iq_size_left = (free >= SAT_C) ? 3'd4 : free[2:0];
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_valid[k] = count > CNT_W'(k);
            issue_elements[k] = mem[rd_idx[k]];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH 16, ISSUE_W 2).
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    ISSUE_QUEUE_ELEMENT [3:0] push_elements;
    logic [2:0] issue_queue_push_number;
    logic [2:0] iq_size_left;
    ISSUE_QUEUE_ELEMENT [1:0] issue_elements;
    bool [1:0] issue_valid;
    logic [1:0] issue_pop_number;
    bool overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    issue_queue #(.DEPTH(16), .ISSUE_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push_elements(push_elements),
        .issue_queue_push_number(issue_queue_push_number),
        .iq_size_left(iq_size_left),
        .issue_elements(issue_elements),
        .issue_valid(issue_valid),
        .issue_pop_number(issue_pop_number),
        .overflow_err(overflow_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic ISSUE_QUEUE_ELEMENT mk(input int t);
        ISSUE_QUEUE_ELEMENT e;
        e.pc = 32'h8000_0000 + 32'(t * 4);
        e.opcode = 7'(t);
        e.rd = 5'(t);
        e.rs1 = 5'(t + 1);
        e.rs2 = 5'(t + 2);
        e.imm = ~32'(t);
        e.require = DECODE_REQUIRE'(2'(t));
        return e;
    endfunction

    // Drive one cycle; checks happen 1 time unit after the edge.
    task automatic drive(input int base, input int np, input int pp, input logic fl);
        for (int i = 0; i < 4; i++) push_elements[i] = mk(base + i);
        issue_queue_push_number = 3'(np);
        issue_pop_number = 2'(pp);
        flush = fl;
        @(posedge clk);
        #1;
        issue_queue_push_number = '0;
        issue_pop_number = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (issue_valid !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valid got %b want 00", issue_valid);
        end
        n_cmp++;
        if (iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL reset_size got %0d want 4", iq_size_left);
        end
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf got %b want 0", overflow_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_push();
        drive(1, 4, 0, 1'b0);
        n_cmp++;
        if (issue_valid !== 2'b11) begin
            n_err++;
            $display("FAIL basic_valid got %b want 11", issue_valid);
        end
        n_cmp++;
        if (issue_elements[0] !== mk(1)) begin
            n_err++;
            $display("FAIL basic_e0 got %h want %h", issue_elements[0], mk(1));
        end
        n_cmp++;
        if (issue_elements[1] !== mk(2)) begin
            n_err++;
            $display("FAIL basic_e1 got %h want %h", issue_elements[1], mk(2));
        end
        n_cmp++;
        if (iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL basic_size got %0d want 4", iq_size_left);
        end
    endtask

    task automatic test_fill();
        drive(5, 4, 0, 1'b0);
        n_cmp++;
        if (iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL fill8_size got %0d want 4", iq_size_left);
        end
        drive(9, 4, 0, 1'b0);
        n_cmp++;
        if (iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL fill12_size got %0d want 4", iq_size_left);
        end
        drive(13, 4, 0, 1'b0);
        n_cmp++;
        if (iq_size_left !== 3'd0) begin
            n_err++;
            $display("FAIL fill16_size got %0d want 0", iq_size_left);
        end
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL fill16_ovf got %b want 0", overflow_err);
        end
        drive(17, 1, 0, 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_ovf got %b want 1", overflow_err);
        end
        n_cmp++;
        if (issue_elements[0] !== mk(1)) begin
            n_err++;
            $display("FAIL full_push_head got %h want %h", issue_elements[0], mk(1));
        end
        drive(0, 0, 2, 1'b0);
        n_cmp++;
        if (iq_size_left !== 3'd2) begin
            n_err++;
            $display("FAIL full_pop_size got %0d want 2", iq_size_left);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 4, 0, 1'b0);
        drive(5, 4, 0, 1'b0);
        drive(9, 4, 0, 1'b0);
        drive(13, 4, 2, 1'b0);
        for (int c = 0; c < 5; c++) drive(17 + 2 * c, 2, 2, 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b0 || iq_size_left !== 3'd2) begin
            n_err++;
            $display("FAIL wrap_setup got ovf=%b size=%0d want ovf=0 size=2",
                     overflow_err, iq_size_left);
        end
        n_cmp++;
        if (issue_elements[0] !== mk(13)) begin
            n_err++;
            $display("FAIL wrap_head got %h want %h", issue_elements[0], mk(13));
        end
        drive(27, 4, 0, 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b1 || iq_size_left !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_over got ovf=%b size=%0d want ovf=1 size=0",
                     overflow_err, iq_size_left);
        end
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (issue_valid !== 2'b11 || issue_elements[0] !== mk(13 + 2 * c)
                || issue_elements[1] !== mk(14 + 2 * c)) begin
                n_err++;
                $display("FAIL wrap_order%0d got v=%b %h %h want tags %0d %0d",
                         c, issue_valid, issue_elements[0], issue_elements[1],
                         13 + 2 * c, 14 + 2 * c);
            end
            drive(0, 0, 2, 1'b0);
        end
        n_cmp++;
        if (issue_valid !== 2'b00 || iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL wrap_drain got v=%b size=%0d want 00 4",
                     issue_valid, iq_size_left);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        drive(1, 4, 0, 1'b0);
        drive(5, 4, 0, 1'b0);
        drive(9, 4, 0, 1'b0);
        drive(13, 3, 0, 1'b0);
        drive(16, 4, 2, 1'b0);
        n_cmp++;
        if (iq_size_left !== 3'd2) begin
            n_err++;
            $display("FAIL simul_size got %0d want 2", iq_size_left);
        end
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL simul_ovf got %b want 1", overflow_err);
        end
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (issue_valid !== 2'b11 || issue_elements[0] !== mk(3 + 2 * c)
                || issue_elements[1] !== mk(4 + 2 * c)) begin
                n_err++;
                $display("FAIL simul_order%0d got v=%b %h %h want tags %0d %0d",
                         c, issue_valid, issue_elements[0], issue_elements[1],
                         3 + 2 * c, 4 + 2 * c);
            end
            drive(0, 0, 2, 1'b0);
        end
        n_cmp++;
        if (issue_valid !== 2'b00) begin
            n_err++;
            $display("FAIL simul_drain got %b want 00", issue_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 4, 0, 1'b0);
        drive(5, 4, 0, 1'b0);
        drive(9, 1, 0, 1'b0);
        drive(20, 4, 2, 1'b1);
        n_cmp++;
        if (issue_valid !== 2'b00 || iq_size_left !== 3'd4) begin
            n_err++;
            $display("FAIL flush_state got v=%b size=%0d want 00 4",
                     issue_valid, iq_size_left);
        end
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ovf got %b want 0", overflow_err);
        end
        drive(50, 1, 0, 1'b0);
        n_cmp++;
        if (issue_valid !== 2'b01 || issue_elements[0] !== mk(50)) begin
            n_err++;
            $display("FAIL flush_push got v=%b %h want 01 %h",
                     issue_valid, issue_elements[0], mk(50));
        end
    endtask

    task automatic test_pop_underflow();
        do_reset();
        drive(1, 1, 0, 1'b0);
        drive(0, 0, 2, 1'b0);
        n_cmp++;
        if (issue_valid !== 2'b00 || overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL under_state got v=%b ovf=%b want 00 1",
                     issue_valid, overflow_err);
        end
        drive(40, 2, 0, 1'b0);
        n_cmp++;
        if (issue_valid !== 2'b11 || issue_elements[0] !== mk(40)
            || issue_elements[1] !== mk(41)) begin
            n_err++;
            $display("FAIL under_recover got v=%b %h %h want 11 tags 40 41",
                     issue_valid, issue_elements[0], issue_elements[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 1, 0, 1'b0);
        drive(2, 5, 1, 1'b0);
        drive(6, 1, 0, 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b1 || issue_valid !== 2'b11
            || issue_elements[0] !== mk(2)) begin
            n_err++;
            $display("FAIL arst_pre got ovf=%b v=%b %h want 1 11 tag 2",
                     overflow_err, issue_valid, issue_elements[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (issue_valid !== 2'b00 || iq_size_left !== 3'd4
            || overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL arst_mid got v=%b size=%0d ovf=%b want 00 4 0",
                     issue_valid, iq_size_left, overflow_err);
        end
        #1;
        rst = 1'b0;
        drive(60, 1, 0, 1'b0);
        n_cmp++;
        if (issue_valid !== 2'b01 || issue_elements[0] !== mk(60)) begin
            n_err++;
            $display("FAIL arst_after got v=%b %h want 01 %h",
                     issue_valid, issue_elements[0], mk(60));
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        issue_queue_push_number = '0;
        issue_pop_number = '0;
        for (int i = 0; i < 4; i++) push_elements[i] = mk(0);
        test_reset();
        test_basic_push();
        test_fill();
        test_wrap();
        test_push_pop_same_cycle();
        test_flush();
        test_pop_underflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
